alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 38 +++
 rtl/alu_arbiter_alu.sv | 52 +++++
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter and its datapath
// decoder:
//   N_DEFAULT   default operand/result width
//   OP_*        3-bit ALU operation codes
//   state_t     arbiter FSM encoding (IDLE -> EXEC -> RESP)
//   rr_pick()   round-robin winner for two requesters
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam int N_DEFAULT = 32;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_ZERO = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Winner index for two requesters. On a tie the requester that was not
    // granted last wins; a lone requester always wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return ~last;
        end
        return v1;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu_arbiter_alu
// Purely combinational N-bit ALU with result flags.
// Ports:
//   i_srca, i_srcb  operands (i_srcb is also the full-width shift amount)
//   i_ctrl          operation code (OP_* from alu_arbiter_pkg)
//   o_result        result, modulo 2^N
//   o_zero          result == 0
//   o_sign          result MSB
// ---------------------------------------------------------------------------
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0] i_srca,
    input  logic [N-1:0] i_srcb,
    input  logic [2:0]   i_ctrl,
    output logic [N-1:0] o_result,
    output logic         o_zero,
    output logic         o_sign
);

    // N fits in N+1 bits for any N >= 1, so the out-of-range compare is
    // done one bit wider than the operand to stay width-exact.
    localparam logic [N:0] SHIFT_LIM = (N+1)'(N);

    logic w_shift_oob;

    // The whole srcb is the shift amount; anything >= N clears the result
    // rather than wrapping on the low bits.
    assign w_shift_oob = ({1'b0, i_srcb} >= SHIFT_LIM);

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            OP_ADD:  o_result = i_srca + i_srcb;
            OP_SLL:  o_result = w_shift_oob ? '0 : (i_srca << i_srcb);
            OP_SUB:  o_result = i_srca - i_srcb;
            OP_ZERO: o_result = '0;
            OP_XOR:  o_result = i_srca ^ i_srcb;
            OP_SRL:  o_result = w_shift_oob ? '0 : (i_srca >> i_srcb);
            OP_OR:   o_result = i_srca | i_srcb;
            OP_AND:  o_result = i_srca & i_srcb;
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);
    assign o_sign = o_result[N-1];

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters. A grant in IDLE latches the
// winner's operands, EXEC registers the ALU result and flags, RESP holds
// them until the consumer takes them. One operation is in flight at a time.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqK_valid / reqK_ready    requester K handshake (ready only in IDLE)
//   reqK_srca/srcb/ctrl        requester K operands and opcode
//   rsp_valid / rsp_ready      response handshake
//   rsp_id                     requester that owns the response
//   rsp_result/zero/sign       registered result and flags
//   op_count                   completed responses, wraps at 16 bits
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_srca,
    input  logic [N-1:0] req0_srcb,
    input  logic [2:0]   req0_ctrl,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_srca,
    input  logic [N-1:0] req1_srcb,
    input  logic [2:0]   req1_ctrl,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_sign,
    output logic [15:0]  op_count
);

    state_t       r_state;
    state_t       w_next;

    logic         r_last;      // index granted most recently
    logic         r_id;        // owner of the in-flight operation
    logic [N-1:0] r_opa;
    logic [N-1:0] r_opb;
    logic [2:0]   r_ctrl;
    logic [N-1:0] r_result;
    logic         r_zero;
    logic         r_sign;
    logic [15:0]  r_op_count;

    logic         w_any;
    logic         w_gnt;
    logic         w_accept;
    logic         w_done;
    logic [N-1:0] w_alu_result;
    logic         w_alu_zero;
    logic         w_alu_sign;

    assign w_any    = req0_valid | req1_valid;
    assign w_gnt    = rr_pick(req0_valid, req1_valid, r_last);
    assign w_accept = (r_state == ST_IDLE) && w_any;
    assign w_done   = (r_state == ST_RESP) && rsp_ready;

    // The ALU only ever sees the latched operands, so requesters may change
    // their inputs freely once accepted.
    alu_arbiter_alu #(
        .N (N)
    ) u_alu (
        .i_srca   (r_opa),
        .i_srcb   (r_opb),
        .i_ctrl   (r_ctrl),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero),
        .o_sign   (w_alu_sign)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any)     w_next = ST_EXEC;
            ST_EXEC:                w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Output logic. Ready is combinational off the grant and is forced low
    // while reset is asserted so nothing is accepted into a dying pipeline.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && !reset) begin
                    req0_ready = ~w_gnt;
                    req1_ready =  w_gnt;
                end
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand latch on grant, result capture in EXEC, counter on
    // response handshake. Reset drops any in-flight operation silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_ctrl     <= OP_ADD;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_sign     <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_opa  <= w_gnt ? req1_srca : req0_srca;
                r_opb  <= w_gnt ? req1_srcb : req0_srcb;
                r_ctrl <= w_gnt ? req1_ctrl : req0_ctrl;
                r_id   <= w_gnt;
                r_last <= w_gnt;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_alu_result;
                r_zero   <= w_alu_zero;
                r_sign   <= w_alu_sign;
            end
            if (w_done) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    // r_id only moves on a grant, which cannot happen while RESP is holding.
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_sign   = r_sign;
    assign op_count   = r_op_count;

endmodule
